// File: rtl/alu_pkg.sv
// alu_pkg: opcode, FSM state and flag types shared by the sequential ALU, its interface and bench.
// Latency: none, types and constants only.
// Backpressure: n/a. Build option ALU_SEQ_MUL_EN (used by alu_seq/alu_mul_iter) changes nothing here.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9,
    MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

  // Status bits registered alongside the result.
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request (in_*) and response (out_*) valid/ready bundle between ID/EX and EX/MEM.
// Latency: none, wires only.
// Backpressure: master drives requests and out_ready; slave (the ALU) drives in_ready and the result.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic                carry;
  logic                overflow;
  logic                zero;
  logic                negative;
  logic                err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, negative, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, negative, err
  );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add unsigned multiplier, one partial product per cycle (ALU_SEQ_MUL_EN only).
// Latency: start at edge T, done_o high during the WIDTH-th busy cycle with prod_o holding the full product.
// Backpressure: none; the caller must not restart while busy and must take prod_o on done_o.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [SHW-1:0]     count_q;
  logic               busy_q;
  logic [WIDTH:0]     acc;

  // One step: add multiplicand to the upper half if the current multiplier bit is set, then shift right.
  always_comb begin
    acc    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {acc, prod_q[WIDTH-1:1]};
  end

  assign done_o = busy_q & (count_q == SHW'(WIDTH - 1));
  // The product is exposed as the post-step value so the caller can register it on the done edge.
  assign prod_o = prod_d;

  // Load operands on start, then iterate once per cycle until the last bit is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      prod_q  <= {{WIDTH{1'b0}}, b_i};
      mcand_q <= a_i;
      count_q <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      prod_q  <= prod_d;
      count_q <= count_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU, registered result/flags; ALU_SEQ_MUL_EN adds the iterative MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL when ALU_SEQ_MUL_EN is defined.
// Backpressure: result held stable in HOLD until out_ready; in_ready low in BUSY and in HOLD without out_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;

  alu_op_e          op_e;
  logic             accept;
  logic             is_mul;
  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_c;
  alu_flags_t       flg_c;

  assign op_e          = alu_op_e'(bus.op);
  assign bus.in_ready  = (state_q == S_IDLE) | ((state_q == S_HOLD) & bus.out_ready);
  assign bus.out_valid = (state_q == S_HOLD);
  assign accept        = bus.in_valid & bus.in_ready;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_res;
  alu_flags_t         mul_flg;

  assign is_mul = (op_e == MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept & is_mul),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // MUL flags: carry reports a nonzero upper half; overflow is not defined for MUL.
  always_comb begin
    mul_res          = mul_prod[WIDTH-1:0];
    mul_flg          = '0;
    mul_flg.carry    = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flg.zero     = (mul_res == '0);
    mul_flg.negative = mul_res[WIDTH-1];
  end
`else
  // Without the multiplier MUL decodes as illegal in the op mux below.
  assign is_mul = 1'b0;
`endif

  // Single-cycle op mux; SUB shares the adder via inverted b plus carry-in.
  always_comb begin
    sub_sel = (op_e == SUB);
    b_eff   = sub_sel ? ~bus.b : bus.b;
    sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    shamt   = bus.b[SHW-1:0];
    res_c   = '0;
    flg_c   = '0;
    case (op_e)
      ADD, SUB: begin
        res_c          = sum[WIDTH-1:0];
        flg_c.carry    = sum[WIDTH];
        flg_c.overflow = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      AND:     res_c = bus.a & bus.b;
      OR:      res_c = bus.a | bus.b;
      XOR:     res_c = bus.a ^ bus.b;
      SLT:     res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      SLTU:    res_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      SLL:     res_c = bus.a << shamt;
      SRL:     res_c = bus.a >> shamt;
      SRA:     res_c = $signed(bus.a) >>> shamt;
      default: flg_c.err = 1'b1;
    endcase
    flg_c.zero     = (res_c == '0);
    flg_c.negative = res_c[WIDTH-1];
  end

  // Next state: accepted MUL goes to BUSY, everything else straight to HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = is_mul ? S_BUSY : S_HOLD;
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        if (mul_done) state_d = S_HOLD;
      end
`endif
      S_HOLD: begin
        if (bus.out_ready) state_d = accept ? (is_mul ? S_BUSY : S_HOLD) : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Output registers load on a single-cycle accept or on multiplier completion, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept && !is_mul) begin
      result_q <= res_c;
      flags_q  <= flg_c;
`ifdef ALU_SEQ_MUL_EN
    end else if (mul_done) begin
      result_q <= mul_res;
      flags_q  <= mul_flg;
`endif
    end
  end

  assign bus.result   = result_q;
  assign bus.carry    = flags_q.carry;
  assign bus.overflow = flags_q.overflow;
  assign bus.zero     = flags_q.zero;
  assign bus.negative = flags_q.negative;
  assign bus.err      = flags_q.err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model.
// Latency: expects 1 cycle for single-cycle ops, 33 for MUL when ALU_SEQ_MUL_EN is defined.
// Backpressure: exercises out_ready stalls during back-to-back issue and reset mid-operation.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
    logic         e;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] obs_r;
  logic [4:0]   obs_f;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: results from plain wide/signed arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      s;
    logic [63:0] u;
    int          sh;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % W);
    case (op)
      ADD: begin
        u   = 64'(a) + 64'(b);
        e.r = u[W-1:0];
        e.c = u[W];
        s   = sa + sb;
        e.v = (s > SMAX) || (s < SMIN);
      end
      SUB: begin
        e.r = a - b;
        e.c = (a >= b);
        s   = sa - sb;
        e.v = (s > SMAX) || (s < SMIN);
      end
      AND:  e.r = a & b;
      OR:   e.r = a | b;
      XOR:  e.r = a ^ b;
      SLT:  e.r = (sa < sb) ? W'(1) : W'(0);
      SLTU: e.r = (a < b) ? W'(1) : W'(0);
      SLL:  e.r = a << sh;
      SRL:  e.r = a >> sh;
      SRA:  e.r = W'(sa >>> sh);
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        u   = 64'(a) * 64'(b);
        e.r = u[W-1:0];
        e.c = (u[63:32] != 64'(0));
      end
`endif
      default: e.e = 1'b1;
    endcase
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high, wait (bounded) for the result and compare it.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    int   lat;
    int   rdy_seen;
    int   exp_lat;
    e       = model(op, a, b);
    exp_lat = 1;
`ifdef ALU_SEQ_MUL_EN
    if (op == MUL) exp_lat = W + 1;
`endif
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    lat          = 0;
    rdy_seen     = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.in_ready) rdy_seen++;
    end while (!bus.out_valid && lat < 100);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".ready_while_busy"}, 64'(rdy_seen), 64'd0);
    obs_r = bus.result;
    obs_f = {bus.carry, bus.overflow, bus.zero, bus.negative, bus.err};
    check({tag, ".result"}, 64'(obs_r), 64'(e.r));
    check({tag, ".flags"}, 64'(obs_f), 64'({e.c, e.v, e.z, e.n, e.e}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t         q[$];
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    logic         need;
    logic         stall;
    int           stray;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    pa            = '0;
    pb            = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check("reset.in_ready", 64'(bus.in_ready), 64'd1);
    check("reset.result", 64'(bus.result), 64'd0);
    check("reset.flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.err}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed arithmetic corners
    do_op(ADD, 32'hFFFF_FFFF, 32'h1, "add_wrap");
    check("add_wrap.const", 64'({obs_r, obs_f}), {27'd0, 32'h0, 5'b10100});
    do_op(ADD, 32'h7FFF_FFFF, 32'h1, "add_ovf");
    check("add_ovf.const", 64'({obs_r, obs_f}), {27'd0, 32'h8000_0000, 5'b01010});
    do_op(SUB, 32'h5, 32'h7, "sub_borrow");
    check("sub_borrow.const", 64'({obs_r, obs_f}), {27'd0, 32'hFFFF_FFFE, 5'b00010});
    do_op(SLT, 32'hFFFF_FFFF, 32'h1, "slt");
    check("slt.const", 64'(obs_r), 64'd1);
    do_op(SLTU, 32'hFFFF_FFFF, 32'h1, "sltu");
    check("sltu.const", 64'(obs_r), 64'd0);
    do_op(SRA, 32'h8000_0000, 32'h24, "sra");
    check("sra.const", 64'(obs_r), 64'hF800_0000);
    do_op(SRL, 32'h8000_0000, 32'h24, "srl");
    check("srl.const", 64'(obs_r), 64'h0800_0000);
    do_op(MUL, 32'h0001_0000, 32'h0001_0001, "mul");
`ifdef ALU_SEQ_MUL_EN
    check("mul.const", 64'({obs_r, obs_f}), {27'd0, 32'h0001_0000, 5'b10000});
`else
    check("mul.const", 64'({obs_r, obs_f}), {27'd0, 32'h0, 5'b00101});
`endif
    do_op(4'hF, 32'h1234, 32'h5678, "illegal");
    check("illegal.const", 64'({obs_r, obs_f}), {27'd0, 32'h0, 5'b00101});

    // Back-to-back ADDs with a 3-cycle out_ready stall in the middle
    need = 1'b1;
    for (int i = 0; i < 14; i++) begin
      stall = (i >= 5) && (i < 8);
      if (need) begin
        pa = W'($urandom);
        pb = W'($urandom);
      end
      bus.op        = ADD;
      bus.a         = pa;
      bus.b         = pb;
      bus.in_valid  = 1'b1;
      bus.out_ready = !stall;
      @(negedge clk);
      check("b2b.in_ready", 64'(bus.in_ready), 64'((i == 0) || !stall));
      if (i > 0) begin
        check("b2b.out_valid", 64'(bus.out_valid), 64'd1);
        check("b2b.result", 64'(bus.result), 64'(q[0].r));
        check("b2b.flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.err}),
              64'({q[0].c, q[0].v, q[0].z, q[0].n, q[0].e}));
      end
      if (i > 0 && !stall) void'(q.pop_front());
      need = !stall;
      if (need) q.push_back(model(ADD, pa, pb));
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("b2b.last_valid", 64'(bus.out_valid), 64'd1);
    check("b2b.last_result", 64'(bus.result), 64'(q[0].r));
    @(negedge clk);
    check("b2b.drained", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Randomized ops, all 16 codes, corner-biased operands
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom_range(0, 15)), pick(), pick(), "rand");
    end

    // Reset at T+10 of a MUL
    do_op(ADD, 32'd40, 32'd2, "pre_rst");
    bus.op        = MUL;
    bus.a         = W'($urandom) | W'(1);
    bus.b         = W'($urandom) | W'(1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
`ifdef ALU_SEQ_MUL_EN
    check("mid_mul.in_ready", 64'(bus.in_ready), 64'd0);
    check("mid_mul.result_held", 64'(bus.result), 64'd42);
`else
    check("mid_mul.in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_mul.result_held", 64'(bus.result), 64'd0);
`endif
    rst = 1'b1;
    #1;
    check("rst_mid.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid.result", 64'(bus.result), 64'd0);
    check("rst_mid.flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.err}), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    check("rst_mid.no_stray_valid", 64'(stray), 64'd0);
    check("rst_mid.result_after", 64'(bus.result), 64'd0);
    @(posedge clk);
    #1;
    do_op(ADD, 32'd2, 32'd3, "post_rst");
    check("post_rst.const", 64'(obs_r), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
